led_mode_sequencer: RTL and testbench

Controller that sequences the LED pattern datapath: selects the 2-bit pattern mode and the speed select for the frequency divider. Supports manual stepping and an auto-cycle mode that dwells a fixed number of pattern steps per mode, with pause and resume. Raw board pushbuttons are synchronised and debounced internally. Sits between the board switches/buttons and the divider + pattern-generator pair; it consumes the divider's step tick.

---
 rtl/led_mode_sequencer_pkg.sv | 26 ++
 rtl/led_mode_sequencer_btn_debounce.sv | 58 +++++
 rtl/led_mode_sequencer.sv | 154 +++++++++++++++
 tb/tb_led_mode_sequencer.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/led_mode_sequencer_pkg.sv
// Purpose: shared encodings for the LED mode sequencer and the pattern generator it drives.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package led_mode_sequencer_pkg;

    // Sequencer FSM states; the values are shared with other blocks in the LED controller.
    typedef enum logic [1:0] {
        ST_MANUAL     = 2'd0,
        ST_AUTO_RUN   = 2'd1,
        ST_AUTO_PAUSE = 2'd2
    } seq_state_t;

    // Pattern mode encodings understood by the pattern generator.
    localparam logic [1:0] MODE_0 = 2'd0;
    localparam logic [1:0] MODE_1 = 2'd1;
    localparam logic [1:0] MODE_2 = 2'd2;
    localparam logic [1:0] MODE_3 = 2'd3;

    // Next pattern mode, wrapping from the last implemented mode back to MODE_0.
    function automatic logic [1:0] next_mode(input logic [1:0] cur, input int num_modes);
        logic [1:0] last;
        last = 2'(num_modes - 1);
        return (cur == last) ? MODE_0 : cur + 2'd1;
    endfunction

endpackage

// File: rtl/led_mode_sequencer_btn_debounce.sv
// Purpose: synchronise and debounce one raw pushbutton, emit a one-cycle press pulse on its accepted rising edge.
// Latency: raw rise sampled at edge 0 -> accepted level at edge 1+DEBOUNCE_CYCLES -> press pulse one edge later.
// Backpressure: none; the press pulse is a single-cycle event with no handshake.
//
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_btn          : raw asynchronous button level, active-high
//   o_press        : one-cycle pulse per accepted press (release produces nothing)
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_btn,
    output logic o_press
);

    localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          r_meta;
    logic          r_sync;
    logic          r_level;
    logic          r_level_d;
    logic          r_press;
    logic [CW-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_meta    <= 1'b0;
            r_sync    <= 1'b0;
            r_level   <= 1'b0;
            r_level_d <= 1'b0;
            r_press   <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_meta <= i_btn;
            r_sync <= r_meta;
            // Count consecutive cycles the synchronised input disagrees with the
            // accepted level; any agreement (a bounce back) restarts the run.
            if (r_sync != r_level) begin
                if (r_cnt == CNT_LAST) begin
                    r_level <= r_sync;
                    r_cnt   <= '0;
                end else begin
                    r_cnt <= r_cnt + CW'(1);
                end
            end else begin
                r_cnt <= '0;
            end
            r_level_d <= r_level;
            r_press   <= r_level & ~r_level_d;
        end
    end

    assign o_press = r_press;

endmodule

// File: rtl/led_mode_sequencer.sv
// Purpose: pick the LED pattern mode and divider speed from buttons, auto-cycle switch and step tick.
// Latency: registered outputs; a consumed press/tick/switch event updates outputs on the following edge.
// Backpressure: none; tick and button presses are single-cycle events, never stalled.
//
// Ports:
//   i_clk, i_rst_n                       : clock, asynchronous active-low reset
//   i_btn_next, i_btn_pause, i_btn_speed : raw asynchronous pushbuttons, active-high
//   i_auto_en                            : slide switch, 1 = auto-cycle (synchronised, not debounced)
//   i_tick                               : one-cycle step pulse from the frequency divider
//   o_mode_out                           : pattern mode to the pattern generator
//   o_freq_sel                           : divider speed select, 0 = slow, 1 = fast
//   o_paused                             : high while auto-cycling is paused
//   o_mode_strobe                        : one-cycle pulse in the cycle o_mode_out takes a new value
module led_mode_sequencer
    import led_mode_sequencer_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int DWELL_TICKS     = 16,
    parameter int NUM_MODES       = 4
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_btn_next,
    input  logic       i_btn_pause,
    input  logic       i_btn_speed,
    input  logic       i_auto_en,
    input  logic       i_tick,
    output logic [1:0] o_mode_out,
    output logic       o_freq_sel,
    output logic       o_paused,
    output logic       o_mode_strobe
);

    localparam int DW = (DWELL_TICKS > 2) ? $clog2(DWELL_TICKS) : 1;
    localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_TICKS - 1);

    logic w_next_press;
    logic w_pause_press;
    logic w_speed_press;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_next (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_btn   (i_btn_next),
        .o_press (w_next_press)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_pause (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_btn   (i_btn_pause),
        .o_press (w_pause_press)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_speed (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_btn   (i_btn_speed),
        .o_press (w_speed_press)
    );

    logic          r_auto_meta;
    logic          r_auto_sync;
    seq_state_t    r_state;
    seq_state_t    w_state_nxt;
    logic [DW-1:0] r_dwell;
    logic [DW-1:0] w_dwell_nxt;
    logic [1:0]    r_mode;
    logic          r_freq_sel;
    logic          r_paused;
    logic          r_mode_strobe;
    logic          w_advance;

    // Leaving auto mode outranks every same-cycle press; entering auto swallows
    // a same-cycle next press. Expiry and next press together advance only once.
    always_comb begin
        w_state_nxt = r_state;
        w_dwell_nxt = r_dwell;
        w_advance   = 1'b0;
        case (r_state)
            ST_MANUAL: begin
                if (r_auto_sync) begin
                    w_state_nxt = ST_AUTO_RUN;
                    w_dwell_nxt = '0;
                end else if (w_next_press) begin
                    w_advance = 1'b1;
                end
            end
            ST_AUTO_RUN: begin
                if (!r_auto_sync) begin
                    w_state_nxt = ST_MANUAL;
                    w_dwell_nxt = '0;
                end else begin
                    if (w_next_press || (i_tick && (r_dwell == DWELL_LAST))) begin
                        w_advance   = 1'b1;
                        w_dwell_nxt = '0;
                    end else if (i_tick) begin
                        w_dwell_nxt = r_dwell + DW'(1);
                    end
                    if (w_pause_press) begin
                        w_state_nxt = ST_AUTO_PAUSE;
                    end
                end
            end
            ST_AUTO_PAUSE: begin
                if (!r_auto_sync) begin
                    w_state_nxt = ST_MANUAL;
                    w_dwell_nxt = '0;
                end else begin
                    // Ticks are ignored here so the dwell count stays frozen.
                    if (w_next_press) begin
                        w_advance   = 1'b1;
                        w_dwell_nxt = '0;
                    end
                    if (w_pause_press) begin
                        w_state_nxt = ST_AUTO_RUN;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_MANUAL;
                w_dwell_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_auto_meta   <= 1'b0;
            r_auto_sync   <= 1'b0;
            r_state       <= ST_MANUAL;
            r_dwell       <= '0;
            r_mode        <= MODE_0;
            r_freq_sel    <= 1'b0;
            r_paused      <= 1'b0;
            r_mode_strobe <= 1'b0;
        end else begin
            r_auto_meta   <= i_auto_en;
            r_auto_sync   <= r_auto_meta;
            r_state       <= w_state_nxt;
            r_dwell       <= w_dwell_nxt;
            r_mode        <= w_advance ? next_mode(r_mode, NUM_MODES) : r_mode;
            r_mode_strobe <= w_advance;
            r_paused      <= (w_state_nxt == ST_AUTO_PAUSE);
            r_freq_sel    <= r_freq_sel ^ w_speed_press;
        end
    end

    assign o_mode_out    = r_mode;
    assign o_freq_sel    = r_freq_sel;
    assign o_paused      = r_paused;
    assign o_mode_strobe = r_mode_strobe;

endmodule

// File: tb/tb_led_mode_sequencer.sv
// Purpose: self-checking bench for led_mode_sequencer against a behavioural model.
// Latency: n/a.
// Backpressure: n/a.
module tb_led_mode_sequencer;

    localparam int DEB = 4;
    localparam int DWL = 3;
    localparam int NM  = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       btn_next = 1'b0;
    logic       btn_pause = 1'b0;
    logic       btn_speed = 1'b0;
    logic       auto_en = 1'b0;
    logic       tick = 1'b0;
    logic [1:0] mode_out;
    logic       freq_sel;
    logic       paused;
    logic       mode_strobe;

    int total = 0;
    int bad = 0;
    int strobe_seen = 0;

    always #5 clk = ~clk;

    led_mode_sequencer #(
        .DEBOUNCE_CYCLES (DEB),
        .DWELL_TICKS     (DWL),
        .NUM_MODES       (NM)
    ) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_btn_next    (btn_next),
        .i_btn_pause   (btn_pause),
        .i_btn_speed   (btn_speed),
        .i_auto_en     (auto_en),
        .i_tick        (tick),
        .o_mode_out    (mode_out),
        .o_freq_sel    (freq_sel),
        .o_paused      (paused),
        .o_mode_strobe (mode_strobe)
    );

    // Behavioural model. Buttons: index 0 = next, 1 = pause, 2 = speed.
    // h[b][k] is the raw sample taken k+1 edges ago; the synchronised view lags
    // the raw sample by two edges, and a level is accepted once the last DEB
    // synchronised samples all disagree with the current accepted level.
    typedef struct packed {
        logic [2:0][15:0] h;
        logic [2:0]       lvl;
        logic [2:0]       rose;
        logic [2:0]       press;
        logic [15:0]      ah;
        logic             auto_on;
        logic             pz;
        logic [3:0]       dwell;
        logic [1:0]       mode;
        logic             fsel;
        logic             strobe;
    } mdl_t;

    mdl_t m;

    function automatic mdl_t mdl_step(mdl_t c, logic [2:0] raw, logic a_raw, logic tk);
        mdl_t n;
        logic flip;
        logic async;
        logic adv;
        n = c;
        for (int b = 0; b < 3; b++) begin
            flip = 1'b1;
            for (int k = 1; k <= DEB; k++) begin
                if (c.h[b][k] == c.lvl[b]) flip = 1'b0;
            end
            n.lvl[b]   = flip ? ~c.lvl[b] : c.lvl[b];
            n.rose[b]  = flip & ~c.lvl[b];
            n.press[b] = c.rose[b];
            n.h[b]     = {c.h[b][14:0], raw[b]};
        end
        async = c.ah[1];
        n.ah  = {c.ah[14:0], a_raw};
        adv   = 1'b0;
        if (!c.auto_on) begin
            if (async) begin
                n.auto_on = 1'b1;
                n.pz      = 1'b0;
                n.dwell   = 4'd0;
            end else begin
                adv = c.press[0];
            end
        end else if (!async) begin
            n.auto_on = 1'b0;
            n.pz      = 1'b0;
            n.dwell   = 4'd0;
        end else if (!c.pz) begin
            if (c.press[0] || (tk && (int'(c.dwell) == DWL - 1))) begin
                adv     = 1'b1;
                n.dwell = 4'd0;
            end else if (tk) begin
                n.dwell = c.dwell + 4'd1;
            end
            if (c.press[1]) n.pz = 1'b1;
        end else begin
            if (c.press[0]) begin
                adv     = 1'b1;
                n.dwell = 4'd0;
            end
            if (c.press[1]) n.pz = 1'b0;
        end
        if (adv) n.mode = 2'((int'(c.mode) + 1) % NM);
        n.strobe = adv;
        if (c.press[2]) n.fsel = ~c.fsel;
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m <= '0;
        else        m <= mdl_step(m, {btn_speed, btn_pause, btn_next}, auto_en, tick);
    end

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Cycle-by-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        chk("mode_out", int'(mode_out), int'(m.mode));
        chk("freq_sel", int'(freq_sel), int'(m.fsel));
        chk("paused", int'(paused), int'(m.pz));
        chk("mode_strobe", int'(mode_strobe), int'(m.strobe));
        if (mode_strobe) strobe_seen++;
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic set_btn(input int idx, input logic v);
        case (idx)
            0:       btn_next  = v;
            1:       btn_pause = v;
            default: btn_speed = v;
        endcase
    endtask

    task automatic press(input int idx);
        set_btn(idx, 1'b1);
        cyc(10);
        set_btn(idx, 1'b0);
        cyc(10);
    endtask

    task automatic tick_pulse();
        tick = 1'b1;
        cyc(1);
        tick = 1'b0;
        cyc(4);
    endtask

    int wrap_exp[4] = '{2, 3, 0, 1};

    initial begin
        int lat;
        int s;
        int s0;

        // Reset state.
        #3;
        chk("rst_mode", int'(mode_out), 0);
        chk("rst_fsel", int'(freq_sel), 0);
        chk("rst_paused", int'(paused), 0);
        chk("rst_strobe", int'(mode_strobe), 0);
        cyc(2);
        rst_n = 1'b1;
        cyc(3);

        // Manual: held next button gives one press, 7 edges after first sample.
        btn_next = 1'b1;
        lat = -1;
        s = 0;
        for (int k = 1; k <= 20; k++) begin
            cyc(1);
            if (mode_strobe) begin
                s++;
                if (lat < 0) lat = k - 1;
            end
        end
        btn_next = 1'b0;
        chk("first_latency", lat, 7);
        chk("first_strobes", s, 1);
        chk("first_mode", int'(mode_out), 1);
        cyc(10);

        for (int i = 0; i < 4; i++) begin
            press(0);
            chk("wrap_mode", int'(mode_out), wrap_exp[i]);
        end

        // Bounce: toggling every 2 cycles never qualifies.
        s0 = strobe_seen;
        for (int i = 0; i < 6; i++) begin
            btn_next = ~btn_next;
            cyc(2);
        end
        cyc(20);
        chk("bounce_strobes", strobe_seen - s0, 0);
        chk("bounce_mode", int'(mode_out), 1);

        // Auto: advance on every third tick.
        auto_en = 1'b1;
        cyc(5);
        s0 = strobe_seen;
        for (int i = 0; i < 9; i++) tick_pulse();
        chk("auto_mode", int'(mode_out), 0);
        chk("auto_strobes", strobe_seen - s0, 3);

        // Pause with a retained count of 1.
        tick_pulse();
        press(1);
        chk("paused_on", int'(paused), 1);
        s0 = strobe_seen;
        for (int i = 0; i < 10; i++) tick_pulse();
        chk("pause_strobes", strobe_seen - s0, 0);
        chk("pause_mode", int'(mode_out), 0);
        press(1);
        chk("paused_off", int'(paused), 0);
        tick_pulse();
        chk("resume_first", int'(mode_out), 0);
        tick_pulse();
        chk("resume_adv", int'(mode_out), 1);

        // Dwell expiry and next press in the same cycle: one advance.
        tick_pulse();
        tick_pulse();
        s0 = strobe_seen;
        btn_next = 1'b1;
        cyc(7);
        tick = 1'b1;
        cyc(1);
        tick = 1'b0;
        cyc(10);
        btn_next = 1'b0;
        cyc(10);
        chk("simul_mode", int'(mode_out), 2);
        chk("simul_strobes", strobe_seen - s0, 1);
        tick_pulse();
        tick_pulse();
        chk("simul_cleared", int'(mode_out), 2);
        tick_pulse();
        chk("simul_next_adv", int'(mode_out), 3);

        // auto_en falls together with a pause press while paused at count 1.
        tick_pulse();
        press(1);
        chk("pre_drop_paused", int'(paused), 1);
        s0 = strobe_seen;
        btn_pause = 1'b1;
        cyc(5);
        auto_en = 1'b0;
        cyc(10);
        btn_pause = 1'b0;
        cyc(10);
        chk("drop_paused", int'(paused), 0);
        chk("drop_mode", int'(mode_out), 3);
        chk("drop_strobes", strobe_seen - s0, 0);
        press(2);
        chk("speed_toggle", int'(freq_sel), 1);

        // Asynchronous reset mid-dwell.
        for (int i = 0; i < 3; i++) press(0);
        auto_en = 1'b1;
        cyc(5);
        tick_pulse();
        chk("pre_rst_mode", int'(mode_out), 2);
        chk("pre_rst_fsel", int'(freq_sel), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_mode", int'(mode_out), 0);
        chk("arst_fsel", int'(freq_sel), 0);
        chk("arst_paused", int'(paused), 0);
        chk("arst_strobe", int'(mode_strobe), 0);
        cyc(2);
        rst_n = 1'b1;
        cyc(5);
        tick_pulse();
        tick_pulse();
        chk("post_rst_hold", int'(mode_out), 0);
        tick_pulse();
        chk("post_rst_adv", int'(mode_out), 1);

        // Randomised traffic, checked every cycle by the model comparison.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 9) == 0) btn_next  = ~btn_next;
            if ($urandom_range(0, 9) == 0) btn_pause = ~btn_pause;
            if ($urandom_range(0, 11) == 0) btn_speed = ~btn_speed;
            tick = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 299) == 0) auto_en = ~auto_en;
            cyc(1);
        end
        tick = 1'b0;
        cyc(5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
